imem_stream_loader: RTL
=======================

// Module: imem_stream_loader
// PURPOSE
// - Writer side of the instruction path: fills instruction memory with the 32-bit words that the
//   fetch stage and control unit later read and decode.
// - Accepts a byte stream (valid/ready) carrying a 16-bit length header followed by
//   little-endian instruction words.
// - Packs each group of 4 bytes into one word and writes it to instruction memory.
// - Holds the CPU stalled while a load is in progress.
// PARAMETERS
// - ADDR_W  default 8   instruction-memory word-address width; capacity = 2**ADDR_W words
// - DATA_W  default 32  instruction word width; fixed at 32 (4 bytes per word)
// PORTS
// - clk         in   1       system clock, rising edge
// - rst         in   1       reset, asynchronous, active-high
// - start       in   1       one-cycle pulse; begins a load; ignored unless state is IDLE
// - byte_in     in   8       stream data byte
// - byte_valid  in   1       byte_in is valid this cycle
// - byte_ready  out  1       loader accepts a byte this cycle; transfer = byte_valid & byte_ready
// - imem_we     out  1       instruction memory write strobe, one cycle per word
// - imem_addr   out  ADDR_W  word address; first word goes to 0, then increments by 1
// - imem_wdata  out  DATA_W  assembled word; byte0 -> [7:0], byte3 -> [31:24]
// - cpu_stall   out  1       high while loading; CPU must not fetch
// - done        out  1       one-cycle pulse when the load finishes (success or error)
// - error       out  1       sticky; cleared on the next accepted start
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; counters and word assembly register cleared.
//   Reset mid-load aborts the load at once. Words already written stay in memory.
// - Clock and reset: one clock. Reset is asynchronous and active-high.
// - FSM states: IDLE, HDR0, HDR1, DATA, WRITE, CHK, DONE.
// - IDLE: byte_ready=0, cpu_stall=0. On start, clear error and the word index, go to HDR0.
// - HDR0: accept the length low byte. HDR1: accept the length high byte -> len[15:0] (in words).
// - Leaving HDR1:
//   - len==0 -> DONE.
//   - len > 2**ADDR_W -> error=1, DONE, no writes.
//   - otherwise -> DATA.
// - DATA: accept bytes into slots 0..3 of the word assembly register. After slot 3 is
//   accepted, go to WRITE.
// - WRITE: byte_ready=0. Drive imem_we=1, imem_addr=word_idx, imem_wdata=assembled word for
//   exactly 1 cycle. Then:
//   - if word_idx==len-1 -> CHK (macro on) or DONE (macro off);
//   - otherwise word_idx+1 and return to DATA.
// - byte_ready=1 only in HDR0, HDR1, DATA and CHK.
//   A byte_valid gap stalls the FSM in place and changes no state.
// - cpu_stall=1 in every state except IDLE and DONE.
// - DONE: done=1 for 1 cycle, then IDLE. The error value holds until the next start.
// - A start pulse outside IDLE has no effect.
// - Latency: from the accepting edge of a word's 4th byte to the cycle imem_we is high is
//   1 cycle. The minimum cost is 5 cycles per word.
// - word_idx width is ADDR_W+1 so that len == 2**ADDR_W does not wrap.
// CONFIGURATION
// - Macro LOADER_CHECKSUM_EN.
// - Defined:
//   - A running XOR of every data byte is kept (header bytes excluded).
//   - After the last WRITE, CHK accepts 1 trailing byte.
//   - If that byte differs from the XOR, error=1. Then DONE.
//   - Words are already written; error only flags them as untrusted.
// - Undefined:
//   - No CHK state and no XOR logic.
//   - The last WRITE goes directly to DONE.
//   - error is set only by a length overflow.
// TESTING
// - Reset mid-DATA -> next cycle: state IDLE, byte_ready=0, cpu_stall=0, imem_we=0;
//   a new start works normally.
// - start, then bytes 02 00 | 78 56 34 12 | EF BE AD DE ->
//   writes 0x12345678 @0 and 0xDEADBEEF @1, one imem_we pulse each, done pulse, error=0.
// - Header 00 00 -> no imem_we, done pulses 3 cycles after start, error=0, cpu_stall drops.
// - ADDR_W=8, header 01 01 (len=257) -> error=1, done, zero writes;
//   error stays 1 until the next start.
// - byte_valid toggled 1/0 on every cycle while loading 1 word -> same word written.
//   No byte is lost or duplicated.
// - LOADER_CHECKSUM_EN, len=1, word bytes 01 02 03 04:
//   - checksum byte 04 -> error=0;
//   - checksum byte 05 -> error=1;
//   - in both cases the word 0x04030201 is written @0.

Source files
------------

// File: rtl/imem_stream_loader.sv
// Instruction-memory loader: unpacks a length-prefixed little-endian byte stream into 32-bit imem writes.
// Latency: imem_we is high 1 cycle after the edge that accepts a word's 4th byte (at least 5 cycles/word).
// Backpressure: byte_ready is low in IDLE/WRITE/DONE; a byte_valid gap holds the FSM in place.
// Optional feature: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check (CHK state).
`timescale 1ns/1ps
module imem_stream_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_stall,
    output logic              done,
    output logic              error
);

    localparam int unsigned CAP = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        CHK   = 3'd5,
`endif
        DONE  = 3'd6
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       len_q;
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        slot;
    logic [DATA_W-1:0] wbuf;
    logic              error_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    logic [15:0] len_hdr;
    logic        len_over;
    logic        last_word;

    // Full length as seen while the high header byte is on the bus.
    assign len_hdr   = {byte_in, len_q[7:0]};
    assign len_over  = 32'(len_hdr) > CAP;
    // word_idx is one bit wider than the address so a full-memory load does not wrap.
    assign last_word = (32'(word_idx) + 32'd1) == 32'(len_q);

    assign imem_addr  = word_idx[ADDR_W-1:0];
    assign imem_wdata = wbuf;
    assign error      = error_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and Moore outputs; byte_valid stands in for the transfer wherever byte_ready is 1.
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        cpu_stall  = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cpu_stall = 1'b0;
                if (start) state_nxt = HDR0;
            end
            HDR0: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = HDR1;
            end
            HDR1: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (len_hdr == 16'd0 || len_over) state_nxt = DONE;
                    else                              state_nxt = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && slot == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                imem_we = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                state_nxt = last_word ? CHK : DATA;
`else
                state_nxt = last_word ? DONE : DATA;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = DONE;
            end
`endif
            DONE: begin
                cpu_stall = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                cpu_stall = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: header capture, word assembly, word index, sticky error, running checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            word_idx <= '0;
            slot     <= '0;
            wbuf     <= '0;
            error_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        error_q  <= 1'b0;
                        word_idx <= '0;
                        slot     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                HDR0: begin
                    if (byte_valid) len_q[7:0] <= byte_in;
                end
                HDR1: begin
                    if (byte_valid) begin
                        len_q <= len_hdr;
                        if (len_over) error_q <= 1'b1;
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        wbuf[{slot, 3'b000} +: 8] <= byte_in;
                        slot                      <= slot + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum                      <= csum ^ byte_in;
`endif
                    end
                end
                WRITE: begin
                    if (!last_word) word_idx <= word_idx + 1'b1;
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (byte_valid && byte_in != csum) error_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
